// File: rtl/clk_period_meter.sv
// Measures a slow periodic signal in Clk cycles. Reports the rise-to-rise period,
// the rise-to-fall high time, lock (two equal consecutive periods) and loss of signal.
module clk_period_meter #(
    parameter int          CNT_W   = 26,
    parameter int unsigned TIMEOUT = 67108863
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             SigIn,
    input  logic             Clear,
    output logic [CNT_W-1:0] PeriodOut,
    output logic [CNT_W-1:0] HighOut,
    output logic             Valid,
    output logic             Locked,
    output logic             Timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic {WAIT_EDGE, MEASURE} state_t;

    state_t           stateReg, stateNext;
    logic [2:0]       syncReg;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic [CNT_W-1:0] periodReg, periodNext;
    logic [CNT_W-1:0] highReg, highNext;
    logic [CNT_W-1:0] highLatchReg, highLatchNext;
    logic             validReg, validNext;
    logic             lockedReg, lockedNext;
    logic             timeoutReg, timeoutNext;
    logic             havePrevReg, havePrevNext;

    logic rise, fall, atLimit;

    // syncReg[0] is the metastability catcher; edges are judged from stages 1 and 2.
    assign rise    = syncReg[1] & ~syncReg[2];
    assign fall    = ~syncReg[1] & syncReg[2];
    assign atLimit = (cntReg == TIMEOUT_CNT);

    // Soft clear deliberately leaves the synchronizer alone so a high input is not re-detected.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            syncReg <= 3'b000;
        end else begin
            syncReg <= {syncReg[1:0], SigIn};
        end
    end

    always_comb begin
        stateNext     = stateReg;
        cntNext       = atLimit ? cntReg : cntReg + CNT_ONE;
        periodNext    = periodReg;
        highNext      = highReg;
        highLatchNext = highLatchReg;
        validNext     = 1'b0;
        lockedNext    = lockedReg;
        timeoutNext   = timeoutReg;
        havePrevNext  = havePrevReg;

        case (stateReg)
            WAIT_EDGE: begin
                // The first rise only starts timing; the partial period before it is dropped.
                if (rise) begin
                    cntNext     = CNT_ONE;
                    timeoutNext = 1'b0;
                    stateNext   = MEASURE;
                end else if (atLimit) begin
                    timeoutNext = 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    highLatchNext = cntReg;
                end
                // A rise landing exactly on the limit is still a valid period.
                if (rise) begin
                    periodNext   = cntReg;
                    highNext     = highLatchReg;
                    validNext    = 1'b1;
                    cntNext      = CNT_ONE;
                    lockedNext   = havePrevReg & (cntReg == periodReg);
                    havePrevNext = 1'b1;
                end else if (atLimit) begin
                    timeoutNext  = 1'b1;
                    lockedNext   = 1'b0;
                    havePrevNext = 1'b0;
                    periodNext   = '0;
                    highNext     = '0;
                    cntNext      = '0;
                    stateNext    = WAIT_EDGE;
                end
            end
            default: begin
                stateNext = WAIT_EDGE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            stateReg     <= WAIT_EDGE;
            cntReg       <= '0;
            periodReg    <= '0;
            highReg      <= '0;
            highLatchReg <= '0;
            validReg     <= 1'b0;
            lockedReg    <= 1'b0;
            timeoutReg   <= 1'b0;
            havePrevReg  <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            periodReg    <= periodNext;
            highReg      <= highNext;
            highLatchReg <= highLatchNext;
            validReg     <= validNext;
            lockedReg    <= lockedNext;
            timeoutReg   <= timeoutNext;
            havePrevReg  <= havePrevNext;
        end
    end

    assign PeriodOut = periodReg;
    assign HighOut   = highReg;
    assign Valid     = validReg;
    assign Locked    = lockedReg;
    assign Timeout   = timeoutReg;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: stimulus pushes the expected capture for every
// rise that ends a period; a negedge monitor pops and compares on each Valid pulse.
module tb_clk_period_meter;

    localparam int CNT_W = 26;
    localparam int TMO   = 100;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             SigIn;
    logic             Clear;
    logic [CNT_W-1:0] PeriodOut;
    logic [CNT_W-1:0] HighOut;
    logic             Valid;
    logic             Locked;
    logic             Timeout;

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .SigIn    (SigIn),
        .Clear    (Clear),
        .PeriodOut(PeriodOut),
        .HighOut  (HighOut),
        .Valid    (Valid),
        .Locked   (Locked),
        .Timeout  (Timeout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic             locked;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic checkAllZero(input string pfx);
        check({pfx, "_period"},  PeriodOut, '0);
        check({pfx, "_high"},    HighOut,   '0);
        check({pfx, "_valid"},   {{(CNT_W-1){1'b0}}, Valid},   '0);
        check({pfx, "_locked"},  {{(CNT_W-1){1'b0}}, Locked},  '0);
        check({pfx, "_timeout"}, {{(CNT_W-1){1'b0}}, Timeout}, '0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input int p, input int h, input logic l);
        exp_t e;
        e.period = CNT_W'(p);
        e.high   = CNT_W'(h);
        e.locked = l;
        expQ.push_back(e);
    endtask

    // One full period starting with a rise: high for h cycles, low for p-h.
    task automatic cyc(input int p, input int h);
        SigIn = 1'b1;
        repeat (h) tick();
        SigIn = 1'b0;
        repeat (p - h) tick();
    endtask

    always @(negedge Clk) begin
        if (Valid === 1'b1) begin
            txn++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got period=%0d high=%0d locked=%0b want no capture",
                         PeriodOut, HighOut, Locked);
            end else begin
                monE = expQ.pop_front();
                $display("txn %0d: period=%0d high=%0d locked=%0b (want %0d/%0d/%0b)",
                         txn, PeriodOut, HighOut, Locked, monE.period, monE.high, monE.locked);
                check("cap_period",  PeriodOut, monE.period);
                check("cap_high",    HighOut,   monE.high);
                check("cap_locked",  {{(CNT_W-1){1'b0}}, Locked},  {{(CNT_W-1){1'b0}}, monE.locked});
                check("cap_timeout", {{(CNT_W-1){1'b0}}, Timeout}, '0);
            end
        end
    end

    initial begin
        Rst   = 1'b1;
        Clear = 1'b0;
        SigIn = 1'b0;
        repeat (3) tick();
        Rst = 1'b0;
        checkAllZero("reset");
        repeat (50) tick();
        checkAllZero("idle");

        // Period 22 / high 11: first rise only arms, then unlocked, then locked.
        cyc(22, 11);
        push(22, 11, 1'b0); cyc(22, 11);
        push(22, 11, 1'b1); cyc(22, 11);

        // Switch to period 30 / high 15.
        push(22, 11, 1'b1); cyc(30, 15);
        push(30, 15, 1'b0); cyc(30, 15);
        push(30, 15, 1'b1); cyc(30, 15);
        check("locked_at_30", {{(CNT_W-1){1'b0}}, Locked}, CNT_W'(1));

        // Last rise, then silence until the counter reaches the limit.
        push(30, 15, 1'b1);
        SigIn = 1'b1;
        for (int i = 1; i <= 103; i++) begin
            tick();
            if (i == 15) SigIn = 1'b0;
            if (i == 102) check("timeout_early", {{(CNT_W-1){1'b0}}, Timeout}, '0);
        end
        check("timeout_set",    {{(CNT_W-1){1'b0}}, Timeout}, CNT_W'(1));
        check("timeout_locked", {{(CNT_W-1){1'b0}}, Locked},  '0);
        check("timeout_period", PeriodOut, '0);
        check("timeout_high",   HighOut,   '0);
        repeat (20) tick();
        check("timeout_hold",   {{(CNT_W-1){1'b0}}, Timeout}, CNT_W'(1));

        // Resume: Timeout drops when the first rise is seen, capture on the second.
        SigIn = 1'b1;
        repeat (2) tick();
        check("timeout_pre_rise", {{(CNT_W-1){1'b0}}, Timeout}, CNT_W'(1));
        tick();
        check("timeout_cleared",  {{(CNT_W-1){1'b0}}, Timeout}, '0);
        repeat (8) tick();
        SigIn = 1'b0;
        repeat (11) tick();
        push(22, 11, 1'b0); cyc(22, 11);
        push(22, 11, 1'b1); cyc(22, 11);

        // Hard reset in a low phase, then soft clear in the high phase of the next period.
        push(22, 11, 1'b1);
        SigIn = 1'b1;
        repeat (11) tick();
        SigIn = 1'b0;
        repeat (5) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        checkAllZero("after_rst");
        repeat (5) tick();
        SigIn = 1'b1;
        repeat (5) tick();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        checkAllZero("after_clear");
        repeat (5) tick();
        SigIn = 1'b0;
        repeat (11) tick();
        cyc(22, 11);
        push(22, 11, 1'b0); cyc(22, 11);
        push(22, 11, 1'b1); cyc(22, 11);

        // Period equal to the timeout limit is still captured.
        push(22, 11, 1'b1); cyc(100, 50);
        check("p100_no_timeout_a", {{(CNT_W-1){1'b0}}, Timeout}, '0);
        push(100, 50, 1'b0); cyc(100, 50);
        check("p100_no_timeout_b", {{(CNT_W-1){1'b0}}, Timeout}, '0);
        push(100, 50, 1'b1);
        SigIn = 1'b1;
        repeat (10) tick();
        check("p100_no_timeout_c", {{(CNT_W-1){1'b0}}, Timeout}, '0);

        for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
        check("queue_drained", CNT_W'(expQ.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
